softmax_sched: RTL and testbench

//  Round-robin scheduler that shares one softmax engine (start/done datapath, Q0.8 outputs)

---
 rtl/softmax_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/softmax_sched.sv | 102 ++++++++++
 tb/tb_softmax_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: state encoding, default vector geometry and a clog2 helper shared by the scheduler and engine
package softmax_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int NODES_DEF = 10;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid request at or above ptr, with wrap
module rr_arbiter #(
    parameter int REQS = 4,
    parameter int IDW = 2
) (
    input  logic [REQS-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [REQS-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic [IDW:0]   s;
    logic [IDW-1:0] k;
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        s = '0;
        k = '0;
        // scan from the farthest offset down so the nearest valid index wins
        for (int i = REQS - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IDW + 1)'(i);
            s = s >= (IDW + 1)'(REQS) ? s - (IDW + 1)'(REQS) : s;
            k = s[IDW-1:0];
            if (req[k]) begin
                gnt = REQS'(1) << k;
                gnt_id = k;
            end
        end
    end
endmodule

// File: rtl/softmax_sched.sv
// softmax_sched: round-robin front end sharing one softmax engine among REQS requesters, with a done watchdog
module softmax_sched
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NODES = NODES_DEF,
    parameter int REQS = 4,
    parameter int IDW = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [REQS-1:0]                  req_valid,
    output logic [REQS-1:0]                  req_ready,
    input  logic [REQS*DATA_WIDTH*NODES-1:0] req_data,
    output logic [REQS-1:0]                  rsp_valid,
    input  logic [REQS-1:0]                  rsp_ready,
    output logic [IDW-1:0]                   rsp_id,
    output logic [DATA_WIDTH*NODES-1:0]      rsp_data,
    output logic                             rsp_error,
    output logic                             eng_start,
    output logic [DATA_WIDTH*NODES-1:0]      eng_inputs,
    input  logic                             eng_done,
    input  logic [DATA_WIDTH*NODES-1:0]      eng_outputs,
    output logic                             busy
);
    localparam int VW = DATA_WIDTH * NODES;
    localparam int CW = clog2(TIMEOUT) + 1;

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr, cur_id, gnt_id;
    logic [REQS-1:0] gnt;
    logic [CW-1:0]   wd_cnt;
    logic            armed, hs, done_ok, tmo, acc;

    rr_arbiter #(.REQS(REQS), .IDW(IDW)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .gnt(gnt),
        .gnt_id(gnt_id)
    );

    // the grant is masked by reset so every output reads 0 while reset_n is low
    assign req_ready = (state == IDLE && reset_n) ? gnt : '0;
    assign hs = |(req_valid & req_ready);
    assign done_ok = armed & eng_done;
    assign tmo = wd_cnt == CW'(TIMEOUT - 1);
    assign acc = rsp_ready[cur_id];
    assign eng_start = state == START;
    assign busy = state != IDLE;
    assign rsp_valid = state == RESP ? REQS'(1) << cur_id : '0;
    assign rsp_id = cur_id;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = hs ? LOAD : IDLE;
            LOAD:    state_n = START;
            START:   state_n = WAIT;
            WAIT:    state_n = (done_ok || tmo) ? RESP : WAIT;
            RESP:    state_n = acc ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            cur_id <= '0;
            wd_cnt <= '0;
            armed <= 1'b0;
            eng_inputs <= '0;
            rsp_data <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (state == IDLE && hs) cur_id <= gnt_id;
            if (state == LOAD) eng_inputs <= req_data[cur_id*VW +: VW];
            if (state == START) begin
                wd_cnt <= '0;
                armed <= 1'b0;
            end
            if (state == WAIT) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + CW'(1);
                // a done level must first be seen low so a stale done from the last run is ignored
                if (!eng_done) armed <= 1'b1;
                if (done_ok) begin
                    rsp_data <= eng_outputs;
                    rsp_error <= 1'b0;
                end else if (tmo) begin
                    rsp_data <= '0;
                    rsp_error <= 1'b1;
                end
            end
            if (state == RESP && acc) rr_ptr <= cur_id == IDW'(REQS - 1) ? '0 : cur_id + IDW'(1);
        end
    end
endmodule

// File: tb/tb_softmax_sched.sv
// tb_softmax_sched: scenario tasks against a softmax engine model and a round-robin reference
module tb_softmax_sched;
    localparam int DW = 8, N = 10, R = 4, IDW = 2, TO = 1024, VW = DW * N;

    logic clk = 1'b0;
    logic reset_n;
    logic [R-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [R*VW-1:0] req_data;
    logic [IDW-1:0] rsp_id;
    logic [VW-1:0] rsp_data, eng_inputs, eng_outputs, auto_out, man_out;
    logic rsp_error, eng_start, eng_done, busy, auto_done, man_done;
    bit eng_auto;
    int eng_delay, exp_ptr, n_cmp, n_bad;

    always #5 clk = ~clk;

    softmax_sched #(.DATA_WIDTH(DW), .NODES(N), .REQS(R), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .eng_start(eng_start), .eng_inputs(eng_inputs),
        .eng_done(eng_done), .eng_outputs(eng_outputs), .busy(busy)
    );

    assign eng_done = eng_auto ? auto_done : man_done;
    assign eng_outputs = eng_auto ? auto_out : man_out;

    // softmax of logits read as signed Q4.4, result floored to Q0.8 and capped at 255
    function automatic logic [VW-1:0] sm(input logic [VW-1:0] x);
        real e[N];
        real s;
        int q;
        s = 0.0;
        for (int i = 0; i < N; i++) begin
            e[i] = $exp($itor($signed(x[i*DW +: DW])) / 16.0);
            s += e[i];
        end
        for (int i = 0; i < N; i++) begin
            q = $rtoi($floor(256.0 * e[i] / s));
            sm[i*DW +: DW] = DW'(q > 255 ? 255 : q);
        end
    endfunction

    function automatic int first_idx(input logic [R-1:0] v, input int p);
        for (int i = 0; i < R; i++) if (v[(p + i) % R]) return (p + i) % R;
        return -1;
    endfunction

    function automatic logic [VW-1:0] slice(input int r);
        return req_data[r*VW +: VW];
    endfunction

    // engine model: done rises eng_delay cycles after start; negative delay never completes
    initial begin
        int left;
        left = -1;
        auto_done = 1'b0;
        auto_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                left = -1;
                auto_done = 1'b0;
            end else if (eng_start) begin
                auto_done = 1'b0;
                left = eng_delay;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    auto_done = 1'b1;
                    auto_out = sm(eng_inputs);
                end
            end
        end
    end

    task automatic rand_data();
        for (int i = 0; i < R * VW / 32; i++) req_data[i*32 +: 32] = $urandom;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept(input int id);
        rsp_ready = R'(1) << id;
        @(negedge clk);
        rsp_ready = '0;
        exp_ptr = (id + 1) % R;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_data = '0;
        #3;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, eng_start, eng_inputs, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b busy=%b eng_start=%b rsp_error=%b required all 0",
                     req_ready, rsp_valid, busy, eng_start, rsp_error);
        end
        req_valid = '0;
        exp_ptr = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        req_data = '0;
        eng_delay = 20;
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (eng_start !== 1'b0) begin n_bad++; $display("FAIL single_start_early: eng_start=%b in LOAD want 0", eng_start); end
        @(negedge clk);
        n_cmp++;
        if (eng_start !== 1'b1) begin n_bad++; $display("FAIL single_start: eng_start=%b 2 cycles after accept want 1", eng_start); end
        wait_rsp(n);
        n_cmp++;
        if (n != 21) begin n_bad++; $display("FAIL single_latency: %0d cycles start->rsp_valid want 21", n); end
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || rsp_error !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rsp: valid=%b id=%0d err=%b want 0010/1/0", rsp_valid, rsp_id, rsp_error);
        end
        n_cmp++;
        for (int i = 0; i < N; i++) begin
            if (rsp_data[i*DW +: DW] !== 8'd25) begin
                n_bad++;
                $display("FAIL single_data: byte %0d = %0d want 25", i, rsp_data[i*DW +: DW]);
                break;
            end
        end
        accept(1);
    endtask

    task automatic test_all_valid();
        int n, starts;
        reset_n = 1'b0;
        req_valid = '1;
        exp_ptr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            rand_data();
            eng_delay = int'($urandom_range(3, 30));
            #1;
            n_cmp++;
            if (req_ready !== R'(1) << (t % R)) begin
                n_bad++;
                $display("FAIL order_grant[%0d]: got %b want requester %0d", t, req_ready, t % R);
            end
            @(negedge clk);
            starts = 0;
            n = 0;
            while (rsp_valid == '0 && n < 3000) begin
                if (eng_start) starts++;
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (starts != 1) begin n_bad++; $display("FAIL order_starts[%0d]: %0d eng_start pulses want 1", t, starts); end
            n_cmp++;
            if (rsp_id !== IDW'(t % R) || rsp_data !== sm(slice(t % R))) begin
                n_bad++;
                $display("FAIL order_rsp[%0d]: id=%0d data=%h want id %0d data %h", t, rsp_id, rsp_data, t % R, sm(slice(t % R)));
            end
            accept(t % R);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_stale();
        rand_data();
        man_out = sm(slice(2));
        man_done = 1'b1;
        eng_auto = 1'b0;
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL stale_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (eng_start !== 1'b1) begin n_bad++; $display("FAIL stale_start: eng_start=%b want 1", eng_start); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== '0) begin n_bad++; $display("FAIL stale_accepted: rsp_valid=%b after stale done want 0000", rsp_valid); end
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== '0) begin n_bad++; $display("FAIL stale_low: rsp_valid=%b with done low want 0000", rsp_valid); end
        man_done = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_data !== man_out || rsp_error !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_rsp: valid=%b data=%h err=%b want 0100/%h/0", rsp_valid, rsp_data, rsp_error, man_out);
        end
        accept(2);
        man_done = 1'b0;
        eng_auto = 1'b1;
    endtask

    task automatic test_timeout();
        int n;
        eng_delay = -1;
        rand_data();
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL tmo_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (eng_start !== 1'b1) begin n_bad++; $display("FAIL tmo_start: eng_start=%b want 1", eng_start); end
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != TO) begin n_bad++; $display("FAIL tmo_wait_cycles: %0d cycles in WAIT want %0d", n, TO); end
        n_cmp++;
        if (rsp_error !== 1'b1 || rsp_data !== '0 || rsp_valid !== 4'b1000 || rsp_id !== 2'd3) begin
            n_bad++;
            $display("FAIL tmo_rsp: err=%b data=%h valid=%b id=%0d want 1/0/1000/3", rsp_error, rsp_data, rsp_valid, rsp_id);
        end
        accept(3);
        eng_delay = int'($urandom_range(3, 40));
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL tmo_next_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        n_cmp++;
        if (rsp_error !== 1'b0 || rsp_data !== sm(slice(0)) || rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL tmo_next_rsp: err=%b data=%h id=%0d want 0/%h/0", rsp_error, rsp_data, rsp_id, sm(slice(0)));
        end
        accept(0);
    endtask

    task automatic test_backpressure();
        int n;
        logic [VW-1:0] exp_d;
        rand_data();
        eng_delay = int'($urandom_range(3, 40));
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        exp_d = sm(slice(1));
        for (int c = 0; c < 50; c++) begin
            rsp_ready = R'($urandom) & ~R'(2);
            req_valid = '1;
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {4'b0010, 2'd1, exp_d, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d req_ready=%b data=%h want 0010/1/0000/%h",
                         c, rsp_valid, rsp_id, req_ready, rsp_data, exp_d);
            end
        end
        req_valid = '0;
        rsp_ready = '0;
        accept(1);
    endtask

    task automatic test_reset_mid();
        int n;
        rand_data();
        eng_delay = 30;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        req_valid = '1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, eng_start, eng_inputs, busy} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: req_ready=%b busy=%b eng_inputs=%h required all 0", req_ready, busy, eng_inputs);
        end
        exp_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        eng_delay = 10;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midreset_prio: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rsp_data !== sm(slice(0))) begin
            n_bad++;
            $display("FAIL midreset_rsp: valid=%b data=%h want 0001/%h", rsp_valid, rsp_data, sm(slice(0)));
        end
        accept(0);
    endtask

    task automatic test_random();
        int n, g;
        logic [R-1:0] mask;
        for (int t = 0; t < 12; t++) begin
            mask = R'($urandom_range(1, 15));
            rand_data();
            eng_delay = int'($urandom_range(3, 40));
            g = first_idx(mask, exp_ptr);
            req_valid = mask;
            #1;
            n_cmp++;
            if (req_ready !== R'(1) << g) begin
                n_bad++;
                $display("FAIL rand_grant[%0d]: valid=%b got %b want requester %0d", t, mask, req_ready, g);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            wait_rsp(n);
            n_cmp++;
            if (n != eng_delay + 1) begin n_bad++; $display("FAIL rand_latency[%0d]: %0d want %0d", t, n, eng_delay + 1); end
            n_cmp++;
            if (rsp_valid !== R'(1) << g || rsp_id !== IDW'(g) || rsp_data !== sm(slice(g)) || rsp_error !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: valid=%b id=%0d data=%h err=%b want id %0d data %h",
                         t, rsp_valid, rsp_id, rsp_data, rsp_error, g, sm(slice(g)));
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            accept(g);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        eng_auto = 1'b1;
        eng_delay = 20;
        man_done = 1'b0;
        man_out = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_stale();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
